// File: rtl/jk_cmd_arbiter_pkg.sv
// Shared types and constants for the JK command arbiter.
package jk_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      ACK   = 2'd2
   } arb_state_e;

   // Command encoding is {J, K}
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Round-robin successor of idx among n requesters
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/jk_cmd_arbiter_if.sv
// Requester-side handshake plus flip-flop control bundle for jk_cmd_arbiter.
interface jk_cmd_arbiter_if #(
   parameter int unsigned N_REQ = 4
);

   logic [N_REQ-1:0]   Req;
   logic [2*N_REQ-1:0] Cmd;
   logic               Q_in;
   logic [N_REQ-1:0]   Gnt;
   logic [N_REQ-1:0]   Ack;
   logic               Q_out;
   logic               J;
   logic               K;
   logic               ClkEn;
   logic               nPr;
   logic               nClr;
   logic               Busy;

   // Requesters plus the shared flip-flop's Q feedback
   modport master (
      output Req, Cmd, Q_in,
      input  Gnt, Ack, Q_out, J, K, ClkEn, nPr, nClr, Busy
   );

   // The arbiter itself
   modport slave (
      input  Req, Cmd, Q_in,
      output Gnt, Ack, Q_out, J, K, ClkEn, nPr, nClr, Busy
   );

endinterface

// File: rtl/jk_cmd_arbiter_rr_pick.sv
// Combinational round-robin winner select: first set req bit scanning from ptr upward,
// wrapping modulo N_REQ.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [PTR_W-1:0] idx_o
);

   // Scan N_REQ positions starting at ptr; first hit wins
   always_comb begin
      int unsigned pos;
      logic [PTR_W-1:0] pos_idx;
      valid_o = 1'b0;
      idx_o   = '0;
      pos     = 0;
      pos_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pos = 32'(ptr_i) + i;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         pos_idx = PTR_W'(pos);
         if (!valid_o && req_i[pos_idx]) begin
            valid_o = 1'b1;
            idx_o   = pos_idx;
         end
      end
   end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Shares one JK flip-flop between N_REQ requesters via IDLE -> APPLY -> ACK sequencing.
// Optional build macro JK_ARB_FIXED_PRIO_EN: lowest index always wins, pointer held at 0.
module jk_cmd_arbiter
   import jk_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = $clog2(N_REQ)
) (
   input logic              Clk,
   input logic              Rst,
   jk_cmd_arbiter_if.slave  bus
);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] win_q, win_d;
   logic [1:0]       cmd_q, cmd_d;
   logic             q_out_q, q_out_d;

   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;
   logic [PTR_W-1:0] pick_ptr;
   logic [N_REQ-1:0] win_oh;

`ifdef JK_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   assign pick_ptr = ptr_q;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_i   (bus.Req),
      .ptr_i   (pick_ptr),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // State register with synchronous reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         cmd_q   <= JK_HOLD;
         q_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cmd_q   <= cmd_d;
         q_out_q <= q_out_d;
      end
   end

   // Next-state: latch winner and its command in IDLE, advance pointer in ACK
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cmd_d   = cmd_q;
      q_out_d = q_out_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               win_d   = pick_idx;
               cmd_d   = bus.Cmd[{pick_idx, 1'b0} +: 2];
               state_d = APPLY;
            end
         end
         APPLY: begin
            state_d = ACK;
         end
         ACK: begin
            q_out_d = bus.Q_in;
`ifdef JK_ARB_FIXED_PRIO_EN
            ptr_d   = '0;
`else
            ptr_d   = PTR_W'(rr_next(32'(win_q), N_REQ));
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: Rst gates everything off at once so an aborted command never acks;
   // Q_out follows Q_in during ACK so it is valid alongside the Ack pulse
   always_comb begin
      win_oh        = '0;
      win_oh[win_q] = 1'b1;
      bus.Gnt       = '0;
      bus.Ack       = '0;
      bus.J         = 1'b0;
      bus.K         = 1'b0;
      bus.ClkEn     = 1'b0;
      bus.Busy      = 1'b0;
      bus.Q_out     = 1'b0;
      bus.nPr       = 1'b1;
      bus.nClr      = ~Rst;
      if (!Rst) begin
         bus.Q_out = q_out_q;
         unique case (state_q)
            APPLY: begin
               bus.Gnt   = win_oh;
               bus.J     = cmd_q[1];
               bus.K     = cmd_q[0];
               bus.ClkEn = 1'b1;
               bus.Busy  = 1'b1;
            end
            ACK: begin
               bus.Gnt   = win_oh;
               bus.Ack   = win_oh;
               bus.Busy  = 1'b1;
               bus.Q_out = bus.Q_in;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Self-checking bench for jk_cmd_arbiter: directed steps plus randomized traffic against a
// transaction-level model (round-robin scan and JK truth table).
module tb_jk_cmd_arbiter;
   import jk_arb_pkg::*;

   localparam int unsigned N = 4;

   logic           Clk = 1'b0;
   logic           Rst;
   logic [N-1:0]   req_v;
   logic [2*N-1:0] cmd_v;
   logic           ff_q = 1'b0;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;
   int m_q    = 0;

   always #5 Clk = ~Clk;

   jk_cmd_arbiter_if #(.N_REQ(N)) bus ();

   jk_cmd_arbiter #(
      .N_REQ (N),
      .PTR_W ($clog2(N))
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   assign bus.Req  = req_v;
   assign bus.Cmd  = cmd_v;
   assign bus.Q_in = ff_q;

   // The shared JK flip-flop
   always @(posedge Clk) begin
      if (!bus.nClr) ff_q <= 1'b0;
      else if (bus.ClkEn) begin
         case ({bus.J, bus.K})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         int k;
         k = (p + i) % N;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   function automatic int model_jk(input int q, input logic [1:0] c);
      case (c)
         JK_RESET:  return 0;
         JK_SET:    return 1;
         JK_TOGGLE: return 1 - q;
         default:   return q;
      endcase
   endfunction

   // Called during an IDLE cycle with requests already driven; ends in the following IDLE cycle
   task automatic txn(input bit scramble);
      int         w;
      int         eq;
      logic [1:0] c;
      w = model_pick(req_v, m_ptr);
      if (w < 0) return;
      c  = cmd_v[2*w +: 2];
      eq = model_jk(m_q, c);
      @(posedge Clk);
      #1;
      if (scramble) begin
         cmd_v[2*w +: 2] = 2'($urandom);
         if ($urandom_range(1, 0) == 1) req_v[w] = 1'b0;
      end
      @(negedge Clk);
      chk("apply_gnt",   32'(bus.Gnt),   32'(1 << w));
      chk("apply_clken", 32'(bus.ClkEn), 32'd1);
      chk("apply_j",     32'(bus.J),     32'(c[1]));
      chk("apply_k",     32'(bus.K),     32'(c[0]));
      chk("apply_ack",   32'(bus.Ack),   32'd0);
      chk("apply_busy",  32'(bus.Busy),  32'd1);
      @(negedge Clk);
      chk("ack_ack",     32'(bus.Ack),   32'(1 << w));
      chk("ack_gnt",     32'(bus.Gnt),   32'(1 << w));
      chk("ack_qout",    32'(bus.Q_out), 32'(eq));
      chk("ack_clken",   32'(bus.ClkEn), 32'd0);
      req_v[w] = 1'b0;
      m_q = eq;
`ifndef JK_ARB_FIXED_PRIO_EN
      m_ptr = (w + 1) % N;
`endif
      @(negedge Clk);
      chk("idle_busy",   32'(bus.Busy),  32'd0);
      chk("idle_ack",    32'(bus.Ack),   32'd0);
   endtask

   initial begin
      Rst   = 1'b1;
      req_v = '0;
      cmd_v = '0;

      // Reset held for two cycles
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         chk("rst_nclr",  32'(bus.nClr),  32'd0);
         chk("rst_npr",   32'(bus.nPr),   32'd1);
         chk("rst_gnt",   32'(bus.Gnt),   32'd0);
         chk("rst_ack",   32'(bus.Ack),   32'd0);
         chk("rst_jk",    32'({bus.J, bus.K, bus.ClkEn}), 32'd0);
         chk("rst_busy",  32'(bus.Busy),  32'd0);
         chk("rst_qout",  32'(bus.Q_out), 32'd0);
      end
      Rst = 1'b0;
      #1;
      chk("rel_nclr", 32'(bus.nClr), 32'd1);
      chk("rel_busy", 32'(bus.Busy), 32'd0);
      m_ptr = 0;
      m_q   = 0;

      // Single set from requester 0
      req_v = 4'b0001;
      cmd_v[1:0] = JK_SET;
      txn(1'b0);

      // Requester 1 resets Q, then requester 2 toggles twice
      req_v[1] = 1'b1;
      cmd_v[3:2] = JK_RESET;
      txn(1'b0);
      for (int i = 0; i < 2; i++) begin
         req_v[2] = 1'b1;
         cmd_v[5:4] = JK_TOGGLE;
         txn(1'b0);
      end

      // Pointer wrap: requesters 3 and 0 together
      req_v = 4'b1001;
      cmd_v[7:6] = JK_HOLD;
      cmd_v[1:0] = JK_SET;
      txn(1'b0);
      txn(1'b0);

      // Reset in the middle of APPLY aborts without Ack
      req_v = 4'b0100;
      cmd_v[5:4] = JK_TOGGLE;
      @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(negedge Clk);
      chk("mid_nclr",  32'(bus.nClr),  32'd0);
      chk("mid_gnt",   32'(bus.Gnt),   32'd0);
      chk("mid_clken", 32'(bus.ClkEn), 32'd0);
      req_v = '0;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk("mid_ffq",   32'(ff_q),      32'd0);
      chk("mid_gnt2",  32'(bus.Gnt),   32'd0);
      chk("mid_ack2",  32'(bus.Ack),   32'd0);
      chk("mid_busy2", 32'(bus.Busy),  32'd0);
      @(negedge Clk);
      chk("mid_ack3",  32'(bus.Ack),   32'd0);
      m_ptr = 0;
      m_q   = 0;

      // Full contention, each requester dropping after its Ack
      req_v = 4'b1111;
      cmd_v = 8'($urandom);
      for (int i = 0; i < 4; i++) txn(1'b0);

      // Hold command still runs the full sequence
      req_v[1] = 1'b1;
      cmd_v[3:2] = JK_HOLD;
      txn(1'b0);

      // Randomized traffic with late Cmd changes and Req drops after latch
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_v[i] && $urandom_range(1, 0) == 1) begin
               req_v[i] = 1'b1;
               cmd_v[2*i +: 2] = 2'($urandom);
            end
         end
         if (req_v == '0) begin
            req_v[0] = 1'b1;
            cmd_v[1:0] = 2'($urandom);
         end
         txn(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
